bin_pack_writer: RTL

Write-side partner of the binarization block: consumes the stream of 1-bit thresholded pixels (address + bit + valid) and packs them eight per byte into a bit-plane frame buffer RAM. Checks that pixel addresses arrive in strict raster order, signals frame completion, and reports its state on two LEDs. Sits between the binarization output and the packed-frame RAM, which the display/readback path reads.

---
 rtl/bin_pack_writer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/bin_pack_writer.sv
// Packs a raster-ordered stream of 1-bit pixels, LSB-first, into bytes for a
// bit-plane frame RAM. Out-of-order addresses abort the frame.
module bin_pack_writer #(
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int ADDR_W = 16
) (
   input  logic              pack_clk,
   input  logic              pack_rst_n,
   input  logic              pack_ctrl,
   input  logic              pix_valid,
   input  logic [ADDR_W-1:0] pix_address,
   input  logic              pix_bit,
   output logic              mem_we,
   output logic [ADDR_W-4:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              frame_done,
   output logic [1:0]        condition_led
);

   localparam int                NPIX      = IMG_W * IMG_H;
   localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(NPIX - 1);
   localparam logic [ADDR_W-4:0] LAST_BYTE = LAST[ADDR_W-1:3];
   localparam bit                ODD_TAIL  = (NPIX % 8) != 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PACK,
      S_FLUSH,
      S_DONE,
      S_ERR
   } state_t;

   state_t              state_q;
   logic                ctrl_q;
   logic [ADDR_W-1:0]   exp_q;
   logic [7:0]          shift_q;
   logic                mem_we_q;
   logic [ADDR_W-4:0]   mem_addr_q;
   logic [7:0]          mem_wdata_q;
   logic                frame_done_q;
   logic [1:0]          led_q;

   logic                start_d;
   logic [7:0]          byte_d;

   function automatic logic [7:0] put_bit(input logic [7:0] b, input logic [2:0] pos,
                                          input logic v);
      logic [7:0] r;
      r      = b;
      r[pos] = v;
      return r;
   endfunction

   assign start_d = pack_ctrl & ~ctrl_q;
   assign byte_d  = put_bit(shift_q, exp_q[2:0], pix_bit);

   always_ff @(posedge pack_clk or negedge pack_rst_n) begin
      if (!pack_rst_n) begin
         state_q      <= S_IDLE;
         ctrl_q       <= 1'b0;
         exp_q        <= '0;
         shift_q      <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         frame_done_q <= 1'b0;
         led_q        <= 2'b00;
      end else begin
         ctrl_q       <= pack_ctrl;
         mem_we_q     <= 1'b0;
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (start_d) begin
                  state_q <= S_PACK;
                  exp_q   <= '0;
                  shift_q <= '0;
                  led_q   <= 2'b01;
               end
            end
            S_PACK: begin
               if (pix_valid) begin
                  if (pix_address != exp_q) begin
                     state_q <= S_ERR;
                     shift_q <= '0;
                     led_q   <= 2'b11;
                  end else begin
                     exp_q <= exp_q + 1'b1;
                     if (exp_q[2:0] == 3'd7) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= exp_q[ADDR_W-1:3];
                        mem_wdata_q <= byte_d;
                        shift_q     <= '0;
                     end else begin
                        shift_q <= byte_d;
                     end
                     // With a byte-aligned frame the last write is already out,
                     // so completion is flagged alongside it.
                     if (exp_q == LAST) begin
                        state_q      <= S_FLUSH;
                        frame_done_q <= !ODD_TAIL;
                     end
                  end
               end
            end
            S_FLUSH: begin
               state_q <= S_DONE;
               led_q   <= 2'b10;
               if (ODD_TAIL) begin
                  mem_we_q     <= 1'b1;
                  mem_addr_q   <= LAST_BYTE;
                  mem_wdata_q  <= shift_q;
                  frame_done_q <= 1'b1;
                  shift_q      <= '0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign frame_done    = frame_done_q;
   assign condition_led = led_q;

endmodule
